// File: rtl/csa_seq_pkg.sv
// Shared types and constants for the serial carry-select adder scheduler.
// No logic and no latency; backpressure is handled by the modules that import this package.
package csa_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int   NIBBLE_W = 4;
    localparam logic REQ0     = 1'b0;
    localparam logic REQ1     = 1'b1;

endpackage

// File: rtl/carry_select_adder_13.sv
// 4-bit carry-select adder slice: purely combinational, with zero-cycle latency and no backpressure.
// Both carry-in cases are precomputed, and the real carry-in picks one of them at the end.
module carry_select_adder_13 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] res_c0;
    logic [4:0] res_c1;

    assign res_c0 = {1'b0, a} + {1'b0, b};
    assign res_c1 = {1'b0, a} + {1'b0, b} + 5'd1;

    assign {cout, sum} = cin ? res_c1 : res_c0;

endmodule

// File: rtl/csa_seq_scheduler.sv
// Round-robin shares one 4-bit adder slice between two requesters and adds W-bit operands one nibble per cycle.
// Latency is NIBBLES+1 cycles from accept to rsp_valid; while rsp_ready is low, rsp_* hold and no request is accepted.
module csa_seq_scheduler
    import csa_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] req0_a,
    input  logic [NIBBLE_W*NIBBLES-1:0] req0_b,
    input  logic                      req0_cin,
    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] req1_a,
    input  logic [NIBBLE_W*NIBBLES-1:0] req1_b,
    input  logic                      req1_cin,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_id,
    output logic [NIBBLE_W*NIBBLES-1:0] rsp_sum,
    output logic                      rsp_cout
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic [KW-1:0]   k_q, k_d;
    logic            id_q, id_d;
    logic            prio_q, prio_d;

    logic            grant_vld;
    logic            grant_id;
    logic [NIBBLE_W-1:0] slice_a, slice_b, slice_sum;
    logic            slice_cout;

    // prio_q names the requester that wins a tie; it flips away from whichever requester was just granted.
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        grant_id  = REQ0;
        if (req0_valid && req1_valid) begin
            grant_id = prio_q;
        end else if (req1_valid) begin
            grant_id = REQ1;
        end
    end

    assign req0_ready = ~rst && (state_q == IDLE) && grant_vld && (grant_id == REQ0);
    assign req1_ready = ~rst && (state_q == IDLE) && grant_vld && (grant_id == REQ1);

    assign slice_a = a_q[int'(k_q)*NIBBLE_W +: NIBBLE_W];
    assign slice_b = b_q[int'(k_q)*NIBBLE_W +: NIBBLE_W];

    carry_select_adder_13 u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        k_d     = k_q;
        id_d    = id_q;
        prio_d  = prio_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    a_d     = (grant_id == REQ1) ? req1_a : req0_a;
                    b_d     = (grant_id == REQ1) ? req1_b : req0_b;
                    carry_d = (grant_id == REQ1) ? req1_cin : req0_cin;
                    id_d    = grant_id;
                    prio_d  = ~grant_id;
                    k_d     = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                sum_d[int'(k_q)*NIBBLE_W +: NIBBLE_W] = slice_sum;
                carry_d = slice_cout;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            id_q    <= REQ0;
            prio_q  <= REQ0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            id_q    <= id_d;
            prio_q  <= prio_d;
        end
    end

    // After the last nibble, carry_q holds the MSB carry-out; it stays frozen while DONE waits for rsp_ready.
    assign rsp_valid = (state_q == DONE);
    assign rsp_sum   = sum_q;
    assign rsp_cout  = carry_q;
    assign rsp_id    = id_q;

endmodule

// File: tb/tb_csa_seq_scheduler.sv
// Directed bench for csa_seq_scheduler with NIBBLES=4.
// Covers sums, carry ripple, arbitration order, response backpressure and mid-operation reset.
module tb_csa_seq_scheduler;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req0_cin;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_cin;
    logic [W-1:0] req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_cout;
    logic [W-1:0] rsp_sum;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    csa_seq_scheduler #(.NIBBLES(NIB)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                             input bit cin, input bit v);
        if (id == 1'b0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_cin = cin;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_cin = cin;
        end
    endtask

    // Offer one request, wait for its grant, and check latency and result with rsp_ready high.
    task automatic run_op(input string tag, input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit cin, input logic [W-1:0] exp_sum, input bit exp_cout);
        int   n;
        logic rdy;
        drive_req(id, a, b, cin, 1'b1);
        #1;
        n   = 0;
        rdy = id ? req1_ready : req0_ready;
        while (!rdy && n < 50) begin
            step();
            #1;
            n++;
            rdy = id ? req1_ready : req0_ready;
        end
        check({tag, "_accept_timeout"}, 32'(n >= 50), 32'd0);
        step();
        drive_req(id, a, b, cin, 1'b0);
        n = 1;
        while (!rsp_valid && n < 50) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(NIB + 1));
        check({tag, "_sum"}, 32'(rsp_sum), 32'(exp_sum));
        check({tag, "_cout"}, 32'(rsp_cout), 32'(exp_cout));
        check({tag, "_id"}, 32'(rsp_id), 32'(id));
        step();
    endtask

    initial begin
        int   n;
        int   hits;
        logic [W-1:0] arb_sum [2];

        rst = 1'b1;
        rsp_ready = 1'b1;
        drive_req(1'b0, '0, '0, 1'b0, 1'b0);
        drive_req(1'b1, '0, '0, 1'b0, 1'b0);
        #12;
        req0_valid = 1'b1;
        #1;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_sum", 32'(rsp_sum), 32'd0);
        check("reset_rsp_cout", 32'(rsp_cout), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check("reset_readies", 32'({req0_ready, req1_ready}), 32'd0);

        // Both requesters are valid from the first cycle after reset.
        drive_req(1'b0, 16'h0101, 16'h0202, 1'b0, 1'b1);
        drive_req(1'b1, 16'h1000, 16'h0FFF, 1'b1, 1'b1);
        arb_sum[0] = 16'h0303;
        arb_sum[1] = 16'h2000;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arb_first_ready", 32'({req0_ready, req1_ready}), 32'b10);
        for (int i = 0; i < 4; i++) begin
            n = 0;
            do begin
                step();
                n++;
                if (i == 0 && n == 1) check("add_readies_low", 32'({req0_ready, req1_ready}), 32'd0);
            end while (!rsp_valid && n < 50);
            check($sformatf("arb_id_%0d", i), 32'(rsp_id), 32'(i % 2));
            check($sformatf("arb_sum_%0d", i), 32'(rsp_sum), 32'(arb_sum[i % 2]));
        end
        drive_req(1'b0, '0, '0, 1'b0, 1'b0);
        drive_req(1'b1, '0, '0, 1'b0, 1'b0);
        step();

        run_op("basic", 1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        run_op("ripple", 1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run_op("allones", 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
        run_op("msb_ovf", 1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);

        // Backpressure: hold DONE for 10 cycles while req1 waits.
        rsp_ready = 1'b0;
        drive_req(1'b0, 16'h00F0, 16'h0F10, 1'b0, 1'b1);
        #1;
        n = 0;
        while (!req0_ready && n < 50) begin step(); #1; n++; end
        check("bp_accept_timeout", 32'(n >= 50), 32'd0);
        step();
        drive_req(1'b0, '0, '0, 1'b0, 1'b0);
        drive_req(1'b1, 16'h0F0F, 16'h0101, 1'b0, 1'b1);
        n = 1;
        while (!rsp_valid && n < 50) begin step(); n++; end
        check("bp_latency", 32'(n), 32'(NIB + 1));
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_hold_%0d", i),
                  32'({rsp_valid, rsp_id, rsp_cout, rsp_sum, req0_ready, req1_ready}),
                  32'({1'b1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0}));
            step();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_req1_wait_in_done", 32'(req1_ready), 32'd0);
        step();
        check("bp_req1_ready_idle", 32'(req1_ready), 32'd1);
        step();
        drive_req(1'b1, '0, '0, 1'b0, 1'b0);
        n = 1;
        while (!rsp_valid && n < 50) begin step(); n++; end
        check("bp_second_sum", 32'(rsp_sum), 32'h1010);
        check("bp_second_id", 32'(rsp_id), 32'd1);
        step();

        // Reset during the second ADD cycle.
        drive_req(1'b0, 16'h1234, 16'h4321, 1'b0, 1'b1);
        #1;
        n = 0;
        while (!req0_ready && n < 50) begin step(); #1; n++; end
        check("rst_accept_timeout", 32'(n >= 50), 32'd0);
        step();
        drive_req(1'b0, '0, '0, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        #1;
        check("midrst_outputs",
              32'({rsp_valid, rsp_sum, rsp_cout, rsp_id, req0_ready, req1_ready}), 32'd0);
        #1;
        rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (rsp_valid) hits++;
        end
        check("midrst_no_response", 32'(hits), 32'd0);
        run_op("after_rst", 1'b1, 16'h0F0F, 16'h0101, 1'b1, 16'h1011, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
